// File: rtl/cinco_pkg.sv
// Shared definitions for the execute-to-memory stage: branch condition
// encodings carried in funct3 and the packed record held by the stage.
package cinco_pkg;

    localparam int CINCO_XLEN       = 32;
    localparam int CINCO_REG_ADDR_W = 5;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef struct packed {
        logic [CINCO_XLEN-1:0]       result;
        logic [CINCO_XLEN-1:0]       store_data;
        logic [CINCO_REG_ADDR_W-1:0] rd;
        logic [2:0]                  funct3;
        logic                        reg_write;
        logic                        mem_read;
        logic                        mem_write;
    } ex_mem_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode from the flags of an a-b subtraction.
// Carry set means no borrow, so the unsigned a<b test is simply ~c.
module branch_cond
    import cinco_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       v,
    input  logic       c,
    input  logic       n,
    input  logic       z,
    output logic       cond
);

    // Six-way condition select; the two unused encodings never branch
    always_comb begin
        cond = 1'b0;
        case (funct3)
            BR_BEQ:  cond = z;
            BR_BNE:  cond = ~z;
            BR_BLT:  cond = n ^ v;
            BR_BGE:  cond = ~(n ^ v);
            BR_BLTU: cond = ~c;
            BR_BGEU: cond = c;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline register. Holds one instruction behind a
// valid/ready handshake, resolves branches and jumps, and raises a single
// cycle PC redirect for every accepted, properly aligned taken transfer.
// A taken transfer to a misaligned target is held with its side effects
// stripped and flagged instead of redirecting.
module ex_mem_stage
    import cinco_pkg::*;
#(
    parameter int XLEN       = CINCO_XLEN,
    parameter int REG_ADDR_W = CINCO_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic [XLEN-1:0]       alu_result,
    input  logic                  v,
    input  logic                  c,
    input  logic                  n,
    input  logic                  z,
    input  logic [2:0]            funct3,
    input  logic                  branch,
    input  logic                  jump,
    input  logic [XLEN-1:0]       target,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [XLEN-1:0]       store_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic [2:0]            out_funct3,
    output logic [XLEN-1:0]       out_store_data,
    output logic                  redirect,
    output logic [XLEN-1:0]       redirect_target,
    output logic                  misaligned
);

    logic      cond;
    logic      taken;
    logic      target_mis;
    logic      accept;
    ex_mem_t   entry_d;
    ex_mem_t   entry_q;
    logic      valid_q;
    logic      redirect_q;
    logic      misaligned_q;
    logic [XLEN-1:0] target_q;

    branch_cond u_branch_cond (
        .funct3 (funct3),
        .v      (v),
        .c      (c),
        .n      (n),
        .z      (z),
        .cond   (cond)
    );

    assign in_ready   = ~valid_q | out_ready;
    assign accept     = in_valid & in_ready & ~flush;
    assign taken      = jump | (branch & cond);
    assign target_mis = taken & (target[1:0] != 2'b00);

    // Build the record to capture; a misaligned transfer must not write anything
    always_comb begin
        entry_d            = '0;
        entry_d.result     = alu_result;
        entry_d.store_data = store_data;
        entry_d.rd         = rd;
        entry_d.funct3     = funct3;
        entry_d.reg_write  = reg_write & ~target_mis;
        entry_d.mem_read   = mem_read  & ~target_mis;
        entry_d.mem_write  = mem_write & ~target_mis;
    end

    // Single-entry buffer: replace on accept, drain on pop, redirect pulses once per accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q      <= '0;
            valid_q      <= 1'b0;
            redirect_q   <= 1'b0;
            misaligned_q <= 1'b0;
            target_q     <= '0;
        end else begin
            redirect_q <= accept & taken & ~target_mis;
            if (accept) begin
                entry_q      <= entry_d;
                valid_q      <= 1'b1;
                misaligned_q <= target_mis;
                target_q     <= target;
            end else if (valid_q & out_ready) begin
                valid_q      <= 1'b0;
                misaligned_q <= 1'b0;
            end
        end
    end

    assign out_valid       = valid_q;
    assign out_result      = entry_q.result;
    assign out_rd          = entry_q.rd;
    assign out_reg_write   = entry_q.reg_write;
    assign out_mem_read    = entry_q.mem_read;
    assign out_mem_write   = entry_q.mem_write;
    assign out_funct3      = entry_q.funct3;
    assign out_store_data  = entry_q.store_data;
    assign redirect        = redirect_q;
    assign redirect_target = target_q;
    assign misaligned      = misaligned_q;

endmodule
